// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and read-mode encoding for the flexible FIFO
package fifo_pkg;
  typedef enum logic {FIFO_STD = 1'b0, FIFO_FWFT = 1'b1} fifo_mode_e;
  function automatic int level_width(int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int ptr_width(int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/fifo_queue_flex_if.sv
// fifo_queue_flex_if: producer/consumer handshake and status bundle of the flexible FIFO
interface fifo_queue_flex_if #(parameter int WIDTH = 16, parameter int DEPTH = 32);
  logic clear, enq, deq, deq_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [WIDTH-1:0] enq_data, deq_data;
  logic [fifo_pkg::level_width(DEPTH)-1:0] level;
  modport master(output clear, enq, enq_data, deq,
                 input deq_data, deq_valid, full, empty, almost_full, almost_empty, level, overflow, underflow);
  modport slave(input clear, enq, enq_data, deq,
                output deq_data, deq_valid, full, empty, almost_full, almost_empty, level, overflow, underflow);
endinterface

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: pointer that counts 0..DEPTH-1 with an explicit wrap, so any depth works
module fifo_wrap_ptr import fifo_pkg::*; #(parameter int DEPTH = 32) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output logic [ptr_width(DEPTH)-1:0] ptr
);
  localparam int PW = ptr_width(DEPTH);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr <= '0;
    else if (clear) ptr <= '0;
    else if (inc) ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
endmodule

// File: rtl/fifo_queue_flex.sv
// fifo_queue_flex: any-depth single-clock FIFO with std/FWFT read, thresholds, sticky errors and flush
module fifo_queue_flex import fifo_pkg::*; #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input logic clk,
  input logic reset_n,
  fifo_queue_flex_if.slave q
);
  localparam int LW = level_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam fifo_mode_e MODE = fifo_mode_e'(FWFT);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] level;
  logic rd_valid, ovf, unf, deq_acc, enq_acc;
  assign deq_acc = q.deq & ~q.empty;
  // a full FIFO still takes a write when a read frees a slot in the same cycle
  assign enq_acc = q.enq & (~q.full | deq_acc);
  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd (.clk(clk), .reset_n(reset_n), .clear(q.clear), .inc(deq_acc), .ptr(rd_ptr));
  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr (.clk(clk), .reset_n(reset_n), .clear(q.clear), .inc(enq_acc), .ptr(wr_ptr));
  always_ff @(posedge clk)
    if (enq_acc && !q.clear) mem[wr_ptr] <= q.enq_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      level    <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (q.clear) begin
      level    <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (enq_acc != deq_acc) level <= enq_acc ? level + LW'(1) : level - LW'(1);
      ovf      <= ovf | (q.enq & ~enq_acc);
      unf      <= unf | (q.deq & q.empty);
      rd_valid <= deq_acc & (MODE == FIFO_STD);
      if (deq_acc) rd_data <= mem[rd_ptr];
    end
  assign q.level        = level;
  assign q.full         = level == LW'(DEPTH);
  assign q.empty        = level == '0;
  assign q.almost_full  = level >= LW'(AF_LEVEL);
  assign q.almost_empty = level <= LW'(AE_LEVEL);
  assign q.overflow     = ovf;
  assign q.underflow    = unf;
  assign q.deq_data     = (MODE == FIFO_FWFT) ? mem[rd_ptr] : rd_data;
  assign q.deq_valid    = (MODE == FIFO_FWFT) ? ~q.empty : rd_valid;
endmodule

// File: tb/tb_fifo_queue_flex.sv
// tb_fifo_queue_flex: directed checks of three FIFO configurations (std D5, FWFT D4, thresholds D8)
module tb_fifo_queue_flex;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fifo_queue_flex_if #(.WIDTH(16), .DEPTH(5)) a ();
  fifo_queue_flex_if #(.WIDTH(16), .DEPTH(4)) b ();
  fifo_queue_flex_if #(.WIDTH(16), .DEPTH(8)) c ();
  fifo_queue_flex #(.WIDTH(16), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2), .FWFT(1'b0)) dut_a (.clk(clk), .reset_n(reset_n), .q(a));
  fifo_queue_flex #(.WIDTH(16), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b1)) dut_b (.clk(clk), .reset_n(reset_n), .q(b));
  fifo_queue_flex #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b0)) dut_c (.clk(clk), .reset_n(reset_n), .q(c));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [15:0] exp_a [6];
    exp_a = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h00AA};
    {a.clear, a.enq, a.deq, a.enq_data} = '0;
    {b.clear, b.enq, b.deq, b.enq_data} = '0;
    {c.clear, c.enq, c.deq, c.enq_data} = '0;
    #12;
    chk("rst_level", a.level, 0);
    chk("rst_empty", a.empty, 1);
    chk("rst_ae", a.almost_empty, 1);
    chk("rst_full", a.full, 0);
    chk("rst_af", a.almost_full, 0);
    chk("rst_dv", a.deq_valid, 0);
    chk("rst_data", a.deq_data, 0);
    chk("rst_ovf", a.overflow, 0);
    chk("rst_unf", a.underflow, 0);
    chk("rst_b_dv", b.deq_valid, 0);
    reset_n = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      a.enq = 1'b1;
      a.enq_data = 16'(i);
      tick();
      chk("fill_level", a.level, i);
      chk("fill_af", a.almost_full, i >= 3);
    end
    chk("fill_full", a.full, 1);
    a.enq_data = 16'h0066;
    tick();
    a.enq = 1'b0;
    chk("ovf_set", a.overflow, 1);
    chk("ovf_level", a.level, 5);
    a.clear = 1'b1;
    tick();
    a.clear = 1'b0;
    chk("clr_ovf", a.overflow, 0);
    chk("clr_level", a.level, 0);
    for (int i = 1; i <= 5; i++) begin
      a.enq = 1'b1;
      a.enq_data = 16'(i);
      tick();
    end
    a.enq = 1'b0;
    chk("refill_full", a.full, 1);
    for (int i = 0; i < 6; i++) begin
      a.deq = 1'b1;
      a.enq = (i == 0);
      a.enq_data = 16'h00AA;
      tick();
      a.enq = 1'b0;
      chk("drain_dv", a.deq_valid, 1);
      chk("drain_data", a.deq_data, exp_a[i]);
      chk("drain_level", a.level, (i == 0) ? 5 : 5 - i);
      if (i == 0) chk("pass_ovf", a.overflow, 0);
    end
    a.deq = 1'b0;
    tick();
    chk("idle_dv", a.deq_valid, 0);
    chk("idle_hold", a.deq_data, 16'h00AA);
    chk("idle_empty", a.empty, 1);
    chk("idle_unf", a.underflow, 0);
    a.deq = 1'b1;
    tick();
    a.deq = 1'b0;
    chk("unf_set", a.underflow, 1);
    chk("unf_level", a.level, 0);
    chk("unf_dv", a.deq_valid, 0);
    a.enq = 1'b1;
    a.deq = 1'b1;
    a.enq_data = 16'h0077;
    tick();
    {a.enq, a.deq} = 2'b00;
    chk("ed_level", a.level, 1);
    chk("ed_unf", a.underflow, 1);
    chk("ed_dv", a.deq_valid, 0);
    a.clear = 1'b1;
    tick();
    a.clear = 1'b0;
    chk("clr2_unf", a.underflow, 0);
    chk("clr2_level", a.level, 0);
    chk("clr2_empty", a.empty, 1);
    chk("clr2_data", a.deq_data, 0);
    tick();
    chk("fw_idle_dv", b.deq_valid, 0);
    b.enq = 1'b1;
    b.enq_data = 16'h1234;
    tick();
    b.enq = 1'b0;
    chk("fw_dv", b.deq_valid, 1);
    chk("fw_head", b.deq_data, 16'h1234);
    b.enq = 1'b1;
    b.enq_data = 16'h5678;
    tick();
    b.enq = 1'b0;
    chk("fw_head_kept", b.deq_data, 16'h1234);
    b.deq = 1'b1;
    tick();
    b.deq = 1'b0;
    chk("fw_pop_data", b.deq_data, 16'h5678);
    chk("fw_pop_dv", b.deq_valid, 1);
    chk("fw_pop_level", b.level, 1);
    b.deq = 1'b1;
    tick();
    b.deq = 1'b0;
    chk("fw_empty_dv", b.deq_valid, 0);
    for (int i = 1; i <= 8; i++) begin
      c.enq = 1'b1;
      c.enq_data = 16'(i);
      tick();
      chk("sw_up_ae", c.almost_empty, i <= 2);
      chk("sw_up_af", c.almost_full, i >= 6);
    end
    c.enq = 1'b0;
    chk("sw_full", c.full, 1);
    for (int i = 7; i >= 0; i--) begin
      c.deq = 1'b1;
      tick();
      chk("sw_dn_level", c.level, i);
      chk("sw_dn_ae", c.almost_empty, i <= 2);
      chk("sw_dn_af", c.almost_full, i >= 6);
    end
    c.deq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a.enq = 1'b1;
      a.enq_data = 16'h0011 * 16'(i + 1);
      tick();
    end
    a.enq = 1'b0;
    chk("mid_level", a.level, 3);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_level", a.level, 0);
    chk("arst_empty", a.empty, 1);
    chk("arst_dv", a.deq_valid, 0);
    tick();
    reset_n = 1'b1;
    tick();
    a.enq = 1'b1;
    a.enq_data = 16'hBEEF;
    tick();
    a.enq = 1'b0;
    a.deq = 1'b1;
    tick();
    a.deq = 1'b0;
    chk("post_dv", a.deq_valid, 1);
    chk("post_data", a.deq_data, 16'hBEEF);
    chk("post_level", a.level, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_queue_flex.md
Name: fifo_queue_flex

Overview:
Parametrised successor to the team's single-clock FIFO queue.
- Any DEPTH ≥ 2, including non-power-of-2 depths, with explicit pointer wrap.
- Correct simultaneous enqueue/dequeue, including pass-through while full.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Fill level, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, synchronous flush.
- Sits between producer/consumer stages in datapath buffering.

Parameters:
- WIDTH, 16, data word width in bits (≥1).
- DEPTH, 32, number of entries (≥2; need not be a power of 2).
- AF_LEVEL, DEPTH-2, almost_full asserts when level ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when level ≤ AE_LEVEL (0..DEPTH-1).
- FWFT, 0, read mode: 0 = registered read (1-cycle latency); 1 = first-word-fall-through.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush.
- enq  in  1  enqueue request.
- enq_data  in  WIDTH  data to enqueue.
- deq  in  1  dequeue request.
- deq_data  out  WIDTH  dequeued/head data.
- deq_valid  out  1  deq_data valid qualifier.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level ≥ AF_LEVEL.
- almost_empty  out  1  level ≤ AE_LEVEL.
- level  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: enqueue rejected.
- underflow  out  1  sticky: dequeue rejected.

Behaviour:
- Reset (reset_n low, async):
  - rd_ptr, wr_ptr and level go to 0; deq_data = 0; deq_valid = 0; overflow = 0; underflow = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are not reset.
- Accept rules, all evaluated on pre-edge state:
  - deq_acc = deq & !empty.
  - enq_acc = enq & (!full | deq_acc). A write to a full FIFO succeeds when a read is accepted in the same cycle.
  - Empty FIFO with enq & deq in the same cycle: enq accepted, deq rejected (underflow set), level becomes 1.
- level next value:
  - +1 when only enq_acc.
  - -1 when only deq_acc.
  - unchanged when both or neither.
  - Never exceeds DEPTH and never wraps below 0.
- Pointers: advance by 1 on acceptance. At DEPTH-1 the next value is 0 (explicit compare, not a power-of-2 rollover).
- Status flags (full, empty, almost_full, almost_empty) are combinational from the registered level.
- FWFT=0:
  - On deq_acc, deq_data <= mem[rd_ptr] and deq_valid = 1 in the next cycle only.
  - Otherwise deq_valid = 0 and deq_data holds its last value.
- FWFT=1:
  - deq_data = mem[rd_ptr] combinationally; deq_valid = !empty.
  - deq pops the head; the new head is visible the cycle after deq_acc.
  - Data written into an empty FIFO is visible the cycle after enq_acc.
- Error flags (sticky):
  - overflow is set on enq & !enq_acc.
  - underflow is set on deq & empty.
  - Both are cleared only by reset or clear.
- clear (synchronous, highest priority after reset):
  - Pointers, level, overflow, underflow and deq_valid go to 0; deq_data goes to 0.
  - enq/deq in the same cycle are ignored and do not set error flags.

Decomposition:
- Package fifo_pkg:
  - function level_width(depth) returning $clog2(depth+1).
  - function ptr_width(depth) returning max(1, $clog2(depth)).
  - enum fifo_mode_e {FIFO_STD=0, FIFO_FWFT=1}.
- Sub-module fifo_wrap_ptr:
  - Parametrised by DEPTH; ports clk, reset_n, clear, inc, ptr.
  - Increments the pointer with wrap at DEPTH-1 -> 0.
  - Instantiated twice, as read and write pointer.

Test Plan:
- DEPTH=5, FWFT=0: enq 0x0001..0x0005 on consecutive cycles -> full=1, level=5, almost_full=1 (AF_LEVEL=3). A 6th enq sets overflow=1 while level stays 5. Five deqs return 0x0001..0x0005 in order, each with deq_valid one cycle after deq.
- DEPTH=5, full: enq 0x00AA and deq in the same cycle -> level stays 5, overflow stays 0. After draining, 0x00AA is the last word out. Pointers have wrapped past index 4.
- Empty FIFO: deq alone -> underflow=1, level=0, deq_valid=0. Then enq & deq together -> level=1, underflow stays 1. Assert clear -> underflow=0, level=0, empty=1.
- FWFT=1, DEPTH=4: enq 0x1234 -> next cycle deq_valid=1, deq_data=0x1234 with no deq issued. Enq 0x5678, then deq -> deq_data=0x5678 the following cycle.
- Reset mid-operation: level=3, then assert reset_n=0 asynchronously between edges -> immediately level=0, empty=1, deq_valid=0. After release, the first enq/deq pair round-trips correctly.
- Threshold sweep with DEPTH=8, AE_LEVEL=2, AF_LEVEL=6: fill from 0 to 8 and back to 0 -> almost_empty high for level 0..2, almost_full high for level 6..8, with transitions at exactly those levels.
